// File: rtl/keypad_scanner_if.sv
// Keypad-side bundle of the 4x4 scanner: row returns in, column drives and
// the debounced key report out.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] key;
    logic       button_pressed;
    logic       multi_key;

    modport master (
        input  row,
        output col,
        output key,
        output button_pressed,
        output multi_key
    );

    modport slave (
        output row,
        input  col,
        input  key,
        input  button_pressed,
        input  multi_key
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, samples the
// synchronised rows once per dwell, classifies each frame and debounces it.
module keypad_scanner #(
    parameter int SCAN_DIV     = 12000,
    parameter int DEBOUNCE_CNT = 5
) (
    input  logic             hwclk,
    input  logic             reset,
    keypad_scanner_if.master kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {RELEASED, PRESSED, MULTI} state_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_SINGLE, CLS_MULTI} cls_t;

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col_idx;
    logic [3:0]       col_q;
    logic [3:0]       row_meta, row_sync;
    logic [1:0]       acc_lows, samp_lows, tot_lows;
    logic [3:0]       acc_code, samp_code, tot_code;
    logic [2:0]       lows_sum;
    logic             dwell_end, frame_end;
    cls_t             frame_cls, prev_cls;
    logic [3:0]       frame_code, prev_code;
    logic [DEB_W-1:0] deb_cnt, deb_next, rel_cnt, rel_next;
    logic             stable, is_held, load_key;
    logic [7:0]       key_q;
    state_t           state, next_state;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b0000: key_code = 4'd1;
            4'b0001: key_code = 4'd2;
            4'b0010: key_code = 4'd3;
            4'b0011: key_code = 4'd10;
            4'b0100: key_code = 4'd4;
            4'b0101: key_code = 4'd5;
            4'b0110: key_code = 4'd6;
            4'b0111: key_code = 4'd11;
            4'b1000: key_code = 4'd7;
            4'b1001: key_code = 4'd8;
            4'b1010: key_code = 4'd9;
            4'b1011: key_code = 4'd12;
            4'b1100: key_code = 4'd14;
            4'b1101: key_code = 4'd0;
            4'b1110: key_code = 4'd15;
            default: key_code = 4'd13;
        endcase
    endfunction

    assign dwell_end = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign frame_end = dwell_end && (col_idx == 2'd3);

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            div_cnt  <= '0;
            col_idx  <= 2'd0;
            col_q    <= 4'b1110;
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= kp.row;
            row_sync <= row_meta;
            if (dwell_end) begin
                div_cnt <= '0;
                col_idx <= col_idx + 2'd1;
                col_q   <= {col_q[2:0], col_q[3]};
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Per-column sample decode, folded into a saturating frame-wide tally
    always_comb begin
        samp_lows = 2'd0;
        samp_code = 4'd0;
        for (int r = 0; r < 4; r++) begin
            if (!row_sync[r]) begin
                samp_code = key_code(2'(r), col_idx);
                if (samp_lows != 2'd2)
                    samp_lows = samp_lows + 2'd1;
            end
        end
        lows_sum   = {1'b0, acc_lows} + {1'b0, samp_lows};
        tot_lows   = (lows_sum >= 3'd2) ? 2'd2 : lows_sum[1:0];
        tot_code   = (acc_lows != 2'd0) ? acc_code : samp_code;
        frame_cls  = (tot_lows == 2'd0) ? CLS_NONE : (tot_lows == 2'd1) ? CLS_SINGLE : CLS_MULTI;
        frame_code = (frame_cls == CLS_SINGLE) ? tot_code : 4'd0;
        deb_next   = DEB_W'(1);
        if (frame_cls == prev_cls && frame_code == prev_code)
            deb_next = (deb_cnt == DEB_W'(DEBOUNCE_CNT)) ? deb_cnt : deb_cnt + DEB_W'(1);
        stable   = (deb_next == DEB_W'(DEBOUNCE_CNT));
        is_held  = (frame_cls == CLS_SINGLE) && (frame_code == key_q[3:0]);
        rel_next = is_held ? '0 : rel_cnt + DEB_W'(1);
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            acc_lows <= 2'd0;
            acc_code <= 4'd0;
        end else if (dwell_end) begin
            acc_lows <= (col_idx == 2'd3) ? 2'd0 : tot_lows;
            acc_code <= (col_idx == 2'd3) ? 4'd0 : tot_code;
        end
    end

    // Any state change restarts the debounce count so the next state needs fresh frames
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            prev_cls  <= CLS_NONE;
            prev_code <= 4'd0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            key_q     <= 8'h00;
        end else if (frame_end) begin
            prev_cls  <= frame_cls;
            prev_code <= frame_code;
            deb_cnt   <= (next_state != state) ? '0 : deb_next;
            rel_cnt   <= (state == PRESSED && next_state == PRESSED) ? rel_next : '0;
            if (load_key)
                key_q <= {4'h0, frame_code};
        end
    end

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset)
            state <= RELEASED;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        load_key   = 1'b0;
        if (frame_end) begin
            case (state)
                RELEASED: begin
                    if (stable && frame_cls == CLS_SINGLE) begin
                        next_state = PRESSED;
                        load_key   = 1'b1;
                    end else if (stable && frame_cls == CLS_MULTI) begin
                        next_state = MULTI;
                    end
                end
                PRESSED: begin
                    if (!is_held && rel_next == DEB_W'(DEBOUNCE_CNT))
                        next_state = RELEASED;
                end
                MULTI: begin
                    if (stable && frame_cls != CLS_MULTI)
                        next_state = RELEASED;
                end
                default: next_state = RELEASED;
            endcase
        end
    end

    assign kp.col            = col_q;
    assign kp.key            = key_q;
    assign kp.button_pressed = (state == PRESSED);
    assign kp.multi_key      = (state == MULTI);
endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix
// (SCAN_DIV=4, DEBOUNCE_CNT=3, so one frame is 16 clocks).
module tb_keypad_scanner;
    localparam logic [15:0] K5    = 16'h0020;
    localparam logic [15:0] K6    = 16'h0040;
    localparam logic [15:0] K8    = 16'h0200;
    localparam logic [15:0] K2    = 16'h0002;
    localparam logic [15:0] K12   = 16'h0003;
    localparam logic [15:0] KHASH = 16'h4000;
    localparam int          NVEC  = 43;

    typedef struct {
        logic [15:0] keys;
        logic        exp_bp;
        logic        exp_mk;
        logic [7:0]  exp_key;
    } frame_vec_t;

    logic        hwclk;
    logic        reset;
    logic [15:0] key_mask;
    logic [3:0]  row_v;
    int          checks;
    int          errors;
    frame_vec_t  vecs [NVEC];
    logic [3:0]  col_pat [4];

    keypad_scanner_if kp_bus ();

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
        .hwclk (hwclk),
        .reset (reset),
        .kp    (kp_bus)
    );

    initial begin
        hwclk = 1'b0;
        forever #5 hwclk = ~hwclk;
    end

    // Mask bit r*4+c closes the switch between row r and column c
    always_comb begin
        row_v = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (key_mask[r*4+c] && !kp_bus.col[c])
                    row_v[r] = 1'b0;
    end
    assign kp_bus.row = row_v;

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic applyStimulus(input logic [15:0] keys, input int cycles);
        key_mask = keys;
        runCycles(cycles);
    endtask

    task automatic doReset(input logic [15:0] keys);
        @(negedge hwclk);
        reset    = 1'b1;
        key_mask = keys;
        runCycles(2);
        reset = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        key_mask = 16'h0000;
        col_pat[0] = 4'b1110;
        col_pat[1] = 4'b1101;
        col_pat[2] = 4'b1011;
        col_pat[3] = 4'b0111;

        vecs[0]  = '{K5,  1'b0, 1'b0, 8'h00};
        vecs[1]  = '{K5,  1'b0, 1'b0, 8'h00};
        vecs[2]  = '{K5,  1'b1, 1'b0, 8'h05};
        vecs[3]  = '{K5,  1'b1, 1'b0, 8'h05};
        vecs[4]  = '{16'h0, 1'b1, 1'b0, 8'h05};
        vecs[5]  = '{16'h0, 1'b1, 1'b0, 8'h05};
        vecs[6]  = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[7]  = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[8]  = '{K8,  1'b0, 1'b0, 8'h05};
        vecs[9]  = '{K8,  1'b0, 1'b0, 8'h05};
        vecs[10] = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[11] = '{K8,  1'b0, 1'b0, 8'h05};
        vecs[12] = '{K8,  1'b0, 1'b0, 8'h05};
        vecs[13] = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[14] = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[15] = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[16] = '{K12, 1'b0, 1'b0, 8'h05};
        vecs[17] = '{K12, 1'b0, 1'b0, 8'h05};
        vecs[18] = '{K12, 1'b0, 1'b1, 8'h05};
        vecs[19] = '{16'h0, 1'b0, 1'b1, 8'h05};
        vecs[20] = '{16'h0, 1'b0, 1'b1, 8'h05};
        vecs[21] = '{16'h0, 1'b0, 1'b0, 8'h05};
        vecs[22] = '{K5,  1'b0, 1'b0, 8'h05};
        vecs[23] = '{K5,  1'b0, 1'b0, 8'h05};
        vecs[24] = '{K5,  1'b1, 1'b0, 8'h05};
        vecs[25] = '{K6,  1'b1, 1'b0, 8'h05};
        vecs[26] = '{K6,  1'b1, 1'b0, 8'h05};
        vecs[27] = '{K6,  1'b0, 1'b0, 8'h05};
        vecs[28] = '{K6,  1'b0, 1'b0, 8'h05};
        vecs[29] = '{K6,  1'b0, 1'b0, 8'h05};
        vecs[30] = '{K6,  1'b1, 1'b0, 8'h06};
        vecs[31] = '{16'h0, 1'b1, 1'b0, 8'h06};
        vecs[32] = '{16'h0, 1'b1, 1'b0, 8'h06};
        vecs[33] = '{16'h0, 1'b0, 1'b0, 8'h06};
        vecs[34] = '{K12, 1'b0, 1'b0, 8'h06};
        vecs[35] = '{K12, 1'b0, 1'b0, 8'h06};
        vecs[36] = '{K12, 1'b0, 1'b1, 8'h06};
        vecs[37] = '{K2,  1'b0, 1'b1, 8'h06};
        vecs[38] = '{K2,  1'b0, 1'b1, 8'h06};
        vecs[39] = '{K2,  1'b0, 1'b0, 8'h06};
        vecs[40] = '{K2,  1'b0, 1'b0, 8'h06};
        vecs[41] = '{K2,  1'b0, 1'b0, 8'h06};
        vecs[42] = '{K2,  1'b1, 1'b0, 8'h02};

        runCycles(2);
        checkOutput("reset col", {4'h0, kp_bus.col}, 8'h0E);
        checkOutput("reset key", kp_bus.key, 8'h00);
        reset = 1'b0;

        // Two idle frames: exact column rotation, outputs stay quiet
        for (int m = 0; m < 32; m++) begin
            checkOutput($sformatf("rotate c%0d col", m), {4'h0, kp_bus.col}, {4'h0, col_pat[(m / 4) % 4]});
            checkOutput($sformatf("rotate c%0d flags", m), {6'h0, kp_bus.button_pressed, kp_bus.multi_key}, 8'h00);
            runCycles(1);
        end
        checkOutput("idle key", kp_bus.key, 8'h00);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].keys, 16);
            checkOutput($sformatf("frame%0d bp", i), {7'h0, kp_bus.button_pressed}, {7'h0, vecs[i].exp_bp});
            checkOutput($sformatf("frame%0d mk", i), {7'h0, kp_bus.multi_key}, {7'h0, vecs[i].exp_mk});
            checkOutput($sformatf("frame%0d key", i), kp_bus.key, vecs[i].exp_key);
            checkOutput($sformatf("frame%0d col", i), {4'h0, kp_bus.col}, 8'h0E);
        end

        // Cycle-exact press and release edges for '5'
        doReset(K5);
        runCycles(47);
        checkOutput("press5 before edge", {7'h0, kp_bus.button_pressed}, 8'h00);
        runCycles(1);
        checkOutput("press5 at edge bp", {7'h0, kp_bus.button_pressed}, 8'h01);
        checkOutput("press5 at edge key", kp_bus.key, 8'h05);
        runCycles(16);
        applyStimulus(16'h0, 47);
        checkOutput("release5 before edge", {7'h0, kp_bus.button_pressed}, 8'h01);
        runCycles(1);
        checkOutput("release5 at edge bp", {7'h0, kp_bus.button_pressed}, 8'h00);
        checkOutput("release5 at edge key", kp_bus.key, 8'h05);

        // Asynchronous reset mid-dwell while '#' is held
        doReset(KHASH);
        runCycles(48);
        checkOutput("hash pressed bp", {7'h0, kp_bus.button_pressed}, 8'h01);
        checkOutput("hash pressed key", kp_bus.key, 8'h0F);
        runCycles(6);
        checkOutput("pre-reset col", {4'h0, kp_bus.col}, 8'h0D);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset key", kp_bus.key, 8'h00);
        checkOutput("async reset bp", {7'h0, kp_bus.button_pressed}, 8'h00);
        checkOutput("async reset mk", {7'h0, kp_bus.multi_key}, 8'h00);
        checkOutput("async reset col", {4'h0, kp_bus.col}, 8'h0E);
        runCycles(2);
        reset = 1'b0;
        runCycles(47);
        checkOutput("rehash before edge", {7'h0, kp_bus.button_pressed}, 8'h00);
        runCycles(1);
        checkOutput("rehash at edge bp", {7'h0, kp_bus.button_pressed}, 8'h01);
        checkOutput("rehash at edge key", kp_bus.key, 8'h0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and produces a key code plus a level press flag.
- Sits directly upstream of the keypad entry accumulator. That block samples `key` on the rising edge of `button_pressed`, so `key` must be valid no later than the cycle `button_pressed` rises.
- Multiple simultaneous keys are suppressed and flagged separately.

Parameters:
- SCAN_DIV, 12000, clocks per column dwell (1 ms at 12 MHz). Minimum legal value 4.
- DEBOUNCE_CNT, 5, consecutive identical frames required to accept a press or a release. Minimum legal value 1.

Ports:
- hwclk  input  1  system clock (12 MHz)
- reset  input  1  asynchronous, active-high reset
- row  input  4  keypad row returns, active-low, externally pulled up
- col  output  4  column drives, active-low, exactly one bit low at a time
- key  output  8  code of last accepted key
- button_pressed  output  1  high while a single debounced key is held
- multi_key  output  1  high while the debounced frame shows 2 or more keys

Behaviour:
- Reset (async, active-high): col=4'b1110, key=0, button_pressed=0, multi_key=0, FSM=RELEASED, all counters 0. Outputs go to these values immediately on assertion, including mid-press.
- Scan:
  - col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110.
  - Each pattern is held exactly SCAN_DIV cycles. One frame = 4*SCAN_DIV cycles.
- Row path:
  - row passes through a 2-flop synchroniser.
  - The synchronised row is sampled on the last cycle of each column's dwell.
- Frame classification, done at the column-3 sample:
  - NONE: no low row bits in any column.
  - SINGLE(code): exactly one low bit in the whole frame.
  - MULTI: 2 or more low bits.
- Key map, row r / column c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Codes: digits = their value (0 -> 0), A=10, B=11, C=12, D=13, *=14, #=15. key[7:4] is always 0.
- Debounce counter:
  - On each frame end, the counter increments if the frame class/code equals the previous frame's, otherwise it loads 1.
  - It saturates at DEBOUNCE_CNT.
  - "Stable" means the counter has reached DEBOUNCE_CNT.
- FSM (transitions only at frame end; outputs registered, updating on the edge after the column-3 sample):
  - RELEASED:
    - Stable SINGLE(k) -> PRESSED: key<=k and button_pressed<=1 on the same edge.
    - Stable MULTI -> MULTI: multi_key<=1.
    - Otherwise stay.
  - PRESSED:
    - Any frame other than SINGLE(current key) counts toward release (none, another key, multi).
    - After DEBOUNCE_CNT consecutive such frames -> RELEASED: button_pressed<=0, key holds its value.
    - A sliding press (5 -> 6 without an empty frame) is therefore a release first. The new key is accepted only after it is stable, starting from RELEASED.
  - MULTI:
    - Stable NONE -> RELEASED, multi_key<=0.
    - Stable SINGLE(k) -> RELEASED, multi_key<=0. A fresh DEBOUNCE_CNT frames of k are then required to reach PRESSED.
    - button_pressed is never asserted in MULTI.
- Press latency: button_pressed rises exactly at the end of the DEBOUNCE_CNT-th consecutive matching frame. Release latency is identical.
- button_pressed and multi_key are never both 1.
- col is driven from a register; no combinational path from row to any output.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3 (frame = 16 cycles).
- Rotation: after reset, col reads 1110, 1101, 1011, 0111, each for exactly 4 cycles, then repeats. key=0, button_pressed=0, multi_key=0 throughout with rows idle (1111).
- Press '5': drive row1 low whenever col1 is active, starting at frame 0.
  - button_pressed rises 1 cycle after the column-3 sample of frame 2.
  - key=0x05 on that same cycle; both held while the key stays down.
- Release: stop driving '5'.
  - button_pressed falls after the 3rd empty frame.
  - key stays 0x05.
- Bounce: '8' present in frames 0 and 1, absent in frame 2, present in frames 3 and 4, then released. button_pressed never rises.
- Multi-key: '1' and '2' held together for 3 frames.
  - multi_key rises at the end of frame 2; button_pressed stays 0.
  - After release, multi_key falls after 3 empty frames.
- Async reset: hold '#' until button_pressed=1 with key=0x0F, then pulse reset mid-dwell.
  - key=0, button_pressed=0, col=1110 immediately, without waiting for a clock edge.
  - With '#' still held, the press is re-accepted 3 frames after reset deasserts.
